ascensor_solicitudes: RTL and testbench
=======================================

// Module: ascensor_solicitudes
// PURPOSE
//  Producer side of the request vector s[9:0] consumed by the elevator algorithm FSM.
//  Edge-detects raw buttons, latches requests, clears them when the car serves a floor.
//  Owns the door open/close FSM; drives `esperar` so the algorithm holds still while the doors are not closed.
//  Sits between the button/cabin panel and the algorithm. Reads back the algorithm's 4-bit state.
// PARAMETERS
//  T_ABIERTA  default 50  cycles the door stays fully open (>=1)
//  T_CIERRE   default 10  cycles spent closing before CERRADA (>=1)
//  CW         default 8   counter width; must hold max(T_ABIERTA,T_CIERRE)
// PORTS
//  clk            in   1   system clock, all state on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  boton          in   10  raw button levels, same bit map as s
//  estado         in   4   algorithm state: [3]=moving, [2]=up, [1:0]=floor (00=F1..11=F4)
//  s              out  10  latched requests: 0=F1 call, 1=F2 down, 2=F2 up, 3=F3 down, 4=F3 up, 5=F4 call, 6..9=cabin F1..F4
//  esperar        out  1   1 = doors not closed, algorithm must not act
//  puerta_abierta out  1   1 while door FSM is in ABIERTA
// BEHAVIOUR
//  Reset (async, rst_n=0): s=0, boton_prev=0, FSM=CERRADA, counter=0. esperar=0 and puerta_abierta=0 while in reset.
//  Edge detect: press[i] = boton[i] & ~boton_prev[i]. boton_prev is registered every cycle.
//   A held button produces exactly one press.
//  Floor hit: hit_mask(f) = cabin bit 6+f plus every hall bit of floor f.
//   F1={0,6}, F2={1,2,7}, F3={3,4,8}, F4={5,9}.
//   floor_hit = ~estado[3] & |(s & hit_mask(estado[1:0])).
//  Door FSM:
//   CERRADA: if floor_hit, go to ABIERTA, load counter=T_ABIERTA-1, clear s & hit_mask (all hall bits of the floor, both directions).
//   ABIERTA: counter decrements. At 0, go to CERRANDO, load T_CIERRE-1.
//     A press inside hit_mask of the current floor reloads T_ABIERTA-1 and is not latched.
//   CERRANDO: counter decrements. At 0, go to CERRADA.
//     A press inside hit_mask of the current floor returns to ABIERTA, reloads T_ABIERTA-1, and is not latched.
//  Latching: s[i] <= (s[i] | press[i]) & ~clear[i].
//   clear = hit_mask of the current floor only on the CERRADA->ABIERTA cycle, and for presses absorbed in ABIERTA/CERRANDO.
//   Same-cycle press and clear on one bit: clear wins.
//   Presses for other floors always latch.
//  esperar: combinational = (FSM!=CERRADA) | floor_hit.
//   The algorithm therefore sees esperar=1 in the very cycle the stop is detected.
//   No cycle exists where the car is stopped on a requested floor with esperar=0.
//  puerta_abierta is registered: 1 from the cycle after entering ABIERTA until leaving it.
//  Door FSM ignores floor_hit while estado[3]=1. If estado[3] rises while FSM!=CERRADA, that is a protocol violation.
//   The FSM continues its timing unchanged; the assertion in the bench flags it.
//  Reset mid-operation: everything returns to the reset values immediately. Latched requests are lost.
//  Counter never underflows: the transition is taken at 0, then the counter is reloaded.
// STRUCTURE
//  Shared include ascensor_defs.vh holds:
//   - s bit indices (S_F1, S_F2_BAJA, S_F2_SUBE, ..., S_CAB4)
//   - estado field positions (E_MOV=3, E_SUBE=2, E_PISO=1:0)
//   - floor codes and door-state encodings (CERRADA, ABIERTA, CERRANDO)
//  One sub-module: puerta_temporizador (load value, load strobe, decrement enable, zero flag; width CW).
//  hit_mask decode and request latch stay inline.
// TESTING
//  1. Reset with boton=0x3FF held -> s=0, esperar=0. Release, then press bit 9 -> s=0x200 after 1 cycle. Holding bit 9 adds no second latch.
//  2. estado=4'b0000 (stopped F1), s={0,6} set -> esperar=1 same cycle. Next cycle s=0, FSM=ABIERTA.
//     T_ABIERTA+T_CIERRE cycles later esperar=0.
//  3. Stopped at F3 with s[3],s[4],s[8] set -> all three cleared on door open. s[5] is untouched and remains 1.
//  4. During CERRANDO at F2, press bit 7 -> FSM=ABIERTA, counter=T_ABIERTA-1, s[7] stays 0.
//  5. Moving (estado=4'b1101), press bit 1 -> s[1]=1, esperar=0, FSM stays CERRADA.
//     Press F2 button and stop-clear in the same cycle -> s[1]=0.
//  6. Assert rst_n=0 mid-ABIERTA -> s=0, FSM=CERRADA, esperar=0 and puerta_abierta=0 immediately, without a clock edge.

Source files
------------

// File: rtl/ascensor_solicitudes_pkg.sv
// Shared constants for the elevator request side: request-vector bit map,
// algorithm-state field positions, floor codes and door FSM states.
package ascensor_solicitudes_pkg;

   localparam int unsigned NS = 10;

   localparam int unsigned S_F1      = 0;
   localparam int unsigned S_F2_BAJA = 1;
   localparam int unsigned S_F2_SUBE = 2;
   localparam int unsigned S_F3_BAJA = 3;
   localparam int unsigned S_F3_SUBE = 4;
   localparam int unsigned S_F4      = 5;
   localparam int unsigned S_CAB1    = 6;
   localparam int unsigned S_CAB2    = 7;
   localparam int unsigned S_CAB3    = 8;
   localparam int unsigned S_CAB4    = 9;

   localparam int unsigned E_MOV     = 3;
   localparam int unsigned E_SUBE    = 2;
   localparam int unsigned E_PISO_HI = 1;
   localparam int unsigned E_PISO_LO = 0;

   typedef enum logic [1:0] {
      PISO_1 = 2'd0,
      PISO_2 = 2'd1,
      PISO_3 = 2'd2,
      PISO_4 = 2'd3
   } piso_e;

   typedef enum logic [1:0] {
      CERRADA  = 2'd0,
      ABIERTA  = 2'd1,
      CERRANDO = 2'd2
   } puerta_e;

endpackage

// File: rtl/ascensor_solicitudes_puerta_temporizador.sv
// Door timer: loadable down-counter that saturates at zero and flags it.
module puerta_temporizador #(
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic          zero_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ascensor_solicitudes.sv
// Request latch and door FSM feeding the elevator algorithm: edge-detects
// buttons, holds requests until served, and stalls the algorithm via esperar.
module ascensor_solicitudes
   import ascensor_solicitudes_pkg::*;
#(
   parameter int unsigned T_ABIERTA = 50,
   parameter int unsigned T_CIERRE  = 10,
   parameter int unsigned CW        = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NS-1:0] boton,
   input  logic [3:0]    estado,
   output logic [NS-1:0] s,
   output logic          esperar,
   output logic          puerta_abierta
);

   localparam logic [CW-1:0] CARGA_ABIERTA = CW'(T_ABIERTA - 1);
   localparam logic [CW-1:0] CARGA_CIERRE  = CW'(T_CIERRE - 1);

   puerta_e       state_q, state_d;
   logic [NS-1:0] s_q, s_d;
   logic [NS-1:0] boton_prev_q;
   logic          puerta_abierta_q;

   logic [NS-1:0] press;
   logic [NS-1:0] mask;
   logic [NS-1:0] clear;
   logic          floor_hit;
   logic          absorb;
   logic          tmr_load;
   logic [CW-1:0] tmr_load_val;
   logic          tmr_dec;
   logic          tmr_zero;
   logic          sube_unused;

   assign sube_unused = estado[E_SUBE];
   assign press       = boton & ~boton_prev_q;

   always_comb begin
      mask = '0;
      case (piso_e'(estado[E_PISO_HI:E_PISO_LO]))
         PISO_1:  begin mask[S_F1] = 1'b1; mask[S_CAB1] = 1'b1; end
         PISO_2:  begin mask[S_F2_BAJA] = 1'b1; mask[S_F2_SUBE] = 1'b1; mask[S_CAB2] = 1'b1; end
         PISO_3:  begin mask[S_F3_BAJA] = 1'b1; mask[S_F3_SUBE] = 1'b1; mask[S_CAB3] = 1'b1; end
         default: begin mask[S_F4] = 1'b1; mask[S_CAB4] = 1'b1; end
      endcase
   end

   assign floor_hit = ~estado[E_MOV] & (|(s_q & mask));
   assign absorb    = |(press & mask);

   // Presses on the served floor while the door is open/closing only extend
   // the door time; they are cleared so they never reach the algorithm.
   always_comb begin
      state_d      = state_q;
      tmr_load     = 1'b0;
      tmr_load_val = CARGA_ABIERTA;
      tmr_dec      = 1'b0;
      clear        = '0;
      case (state_q)
         CERRADA: begin
            if (floor_hit) begin
               state_d  = ABIERTA;
               tmr_load = 1'b1;
               clear    = mask;
            end
         end
         ABIERTA: begin
            if (absorb) begin
               tmr_load = 1'b1;
               clear    = press & mask;
            end else if (tmr_zero) begin
               state_d      = CERRANDO;
               tmr_load     = 1'b1;
               tmr_load_val = CARGA_CIERRE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         CERRANDO: begin
            if (absorb) begin
               state_d  = ABIERTA;
               tmr_load = 1'b1;
               clear    = press & mask;
            end else if (tmr_zero) begin
               state_d = CERRADA;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: state_d = CERRADA;
      endcase
      s_d = (s_q | press) & ~clear;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= CERRADA;
         s_q              <= '0;
         boton_prev_q     <= '0;
         puerta_abierta_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         s_q              <= s_d;
         boton_prev_q     <= boton;
         puerta_abierta_q <= (state_d == ABIERTA);
      end
   end

   puerta_temporizador #(
      .CW (CW)
   ) u_temp (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   assign s              = s_q;
   assign esperar        = (state_q != CERRADA) | floor_hit;
   assign puerta_abierta = puerta_abierta_q;

endmodule

// File: tb/tb_ascensor_solicitudes.sv
// Directed bench for ascensor_solicitudes with short door times.
module tb_ascensor_solicitudes;
   import ascensor_solicitudes_pkg::*;

   localparam int unsigned TA = 4;
   localparam int unsigned TC = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] boton;
   logic [3:0] estado;
   logic [9:0] s;
   logic       esperar;
   logic       puerta_abierta;
   logic       mov_prev = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   ascensor_solicitudes #(
      .T_ABIERTA (TA),
      .T_CIERRE  (TC),
      .CW        (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .boton          (boton),
      .estado         (estado),
      .s              (s),
      .esperar        (esperar),
      .puerta_abierta (puerta_abierta)
   );

   always #5 clk = ~clk;

   // The car must never start moving while the door is not closed.
   always @(posedge clk) begin
      if (rst_n && estado[3] && !mov_prev)
         assert (dut.state_q == CERRADA)
         else $error("protocol violation: car started moving with door state %0d", dut.state_q);
      mov_prev <= estado[3];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; boton = 10'h3FF; estado = 4'b1000;
      #2;
      n_checks++; if (s !== 10'h000) begin n_fail++; $display("FAIL reset_s: got %h want 000", s); end
      n_checks++; if (esperar !== 1'b0) begin n_fail++; $display("FAIL reset_esperar: got %b want 0", esperar); end
      n_checks++; if (puerta_abierta !== 1'b0) begin n_fail++; $display("FAIL reset_puerta: got %b want 0", puerta_abierta); end
      step(); step();
      boton = 10'h000;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_edge_detect();
      boton = 10'h200;
      step();
      n_checks++; if (s !== 10'h200) begin n_fail++; $display("FAIL press_cab4: got %h want 200", s); end
      step(); step();
      n_checks++; if (s !== 10'h200) begin n_fail++; $display("FAIL hold_cab4: got %h want 200", s); end
      estado = 4'b0011;
      #1;
      n_checks++; if (esperar !== 1'b1) begin n_fail++; $display("FAIL f4_hit_esperar: got %b want 1", esperar); end
      step();
      n_checks++; if (s !== 10'h000) begin n_fail++; $display("FAIL f4_clear: got %h want 000", s); end
      n_checks++; if (dut.state_q !== ABIERTA) begin n_fail++; $display("FAIL f4_open: got %0d want %0d", dut.state_q, ABIERTA); end
      for (int k = 1; k <= int'(TA + TC); k++) begin
         step();
         n_checks++;
         if (esperar !== (k < int'(TA + TC))) begin
            n_fail++; $display("FAIL f4_esperar_k%0d: got %b want %b", k, esperar, (k < int'(TA + TC)));
         end
      end
      n_checks++; if (s !== 10'h000) begin n_fail++; $display("FAIL held_no_relatch: got %h want 000", s); end
      boton = 10'h000; estado = 4'b1000;
      step();
   endtask

   task automatic test_stop_f1();
      boton = 10'h041;
      step();
      n_checks++; if (s !== 10'h041) begin n_fail++; $display("FAIL f1_latch: got %h want 041", s); end
      boton = 10'h000; estado = 4'b0000;
      #1;
      n_checks++; if (esperar !== 1'b1) begin n_fail++; $display("FAIL f1_esperar_same_cycle: got %b want 1", esperar); end
      n_checks++; if (puerta_abierta !== 1'b0) begin n_fail++; $display("FAIL f1_puerta_early: got %b want 0", puerta_abierta); end
      step();
      n_checks++; if (s !== 10'h000) begin n_fail++; $display("FAIL f1_clear: got %h want 000", s); end
      n_checks++; if (dut.state_q !== ABIERTA) begin n_fail++; $display("FAIL f1_open: got %0d want %0d", dut.state_q, ABIERTA); end
      n_checks++; if (puerta_abierta !== 1'b1) begin n_fail++; $display("FAIL f1_puerta_open: got %b want 1", puerta_abierta); end
      for (int k = 1; k <= int'(TA + TC); k++) begin
         step();
         n_checks++;
         if (esperar !== (k < int'(TA + TC))) begin
            n_fail++; $display("FAIL f1_esperar_k%0d: got %b want %b", k, esperar, (k < int'(TA + TC)));
         end
         n_checks++;
         if (puerta_abierta !== (k < int'(TA))) begin
            n_fail++; $display("FAIL f1_puerta_k%0d: got %b want %b", k, puerta_abierta, (k < int'(TA)));
         end
      end
      estado = 4'b1000;
      step();
   endtask

   task automatic test_stop_f3();
      estado = 4'b1110; boton = 10'h138;
      step();
      n_checks++; if (s !== 10'h138) begin n_fail++; $display("FAIL f3_latch: got %h want 138", s); end
      boton = 10'h000; estado = 4'b0010;
      #1;
      n_checks++; if (esperar !== 1'b1) begin n_fail++; $display("FAIL f3_esperar: got %b want 1", esperar); end
      step();
      n_checks++; if (s !== 10'h020) begin n_fail++; $display("FAIL f3_clear: got %h want 020", s); end
      for (int k = 1; k <= int'(TA + TC); k++) step();
      n_checks++; if (dut.state_q !== CERRADA) begin n_fail++; $display("FAIL f3_closed: got %0d want %0d", dut.state_q, CERRADA); end
      n_checks++; if (s !== 10'h020) begin n_fail++; $display("FAIL f3_keep_f4: got %h want 020", s); end
      estado = 4'b1110;
      step();
   endtask

   task automatic test_reopen_cerrando();
      boton = 10'h080;
      step();
      n_checks++; if (s !== 10'h0A0) begin n_fail++; $display("FAIL cab2_latch: got %h want 0a0", s); end
      boton = 10'h000; estado = 4'b0001;
      step();
      n_checks++; if (s !== 10'h020) begin n_fail++; $display("FAIL f2_clear: got %h want 020", s); end
      for (int k = 1; k <= int'(TA); k++) step();
      n_checks++; if (dut.state_q !== CERRANDO) begin n_fail++; $display("FAIL f2_closing: got %0d want %0d", dut.state_q, CERRANDO); end
      boton = 10'h080;
      step();
      n_checks++; if (dut.state_q !== ABIERTA) begin n_fail++; $display("FAIL reopen_state: got %0d want %0d", dut.state_q, ABIERTA); end
      n_checks++; if (dut.u_temp.cnt_q !== 4'(TA - 1)) begin n_fail++; $display("FAIL reopen_counter: got %0d want %0d", dut.u_temp.cnt_q, TA - 1); end
      n_checks++; if (s !== 10'h020) begin n_fail++; $display("FAIL reopen_not_latched: got %h want 020", s); end
      boton = 10'h001;
      step();
      n_checks++; if (s !== 10'h021) begin n_fail++; $display("FAIL other_floor_latch: got %h want 021", s); end
      boton = 10'h000;
      for (int k = 2; k <= int'(TA + TC); k++) begin
         step();
         n_checks++;
         if (esperar !== (k < int'(TA + TC))) begin
            n_fail++; $display("FAIL reopen_esperar_k%0d: got %b want %b", k, esperar, (k < int'(TA + TC)));
         end
      end
      estado = 4'b1101;
      step();
   endtask

   task automatic test_moving_latch();
      boton = 10'h002;
      step();
      n_checks++; if (s !== 10'h023) begin n_fail++; $display("FAIL moving_latch: got %h want 023", s); end
      n_checks++; if (esperar !== 1'b0) begin n_fail++; $display("FAIL moving_esperar: got %b want 0", esperar); end
      n_checks++; if (dut.state_q !== CERRADA) begin n_fail++; $display("FAIL moving_state: got %0d want %0d", dut.state_q, CERRADA); end
      boton = 10'h000;
      step();
      estado = 4'b0001; boton = 10'h002;
      #1;
      n_checks++; if (esperar !== 1'b1) begin n_fail++; $display("FAIL f2_stop_esperar: got %b want 1", esperar); end
      step();
      n_checks++; if (s !== 10'h021) begin n_fail++; $display("FAIL clear_wins: got %h want 021", s); end
      n_checks++; if (dut.state_q !== ABIERTA) begin n_fail++; $display("FAIL f2_stop_open: got %0d want %0d", dut.state_q, ABIERTA); end
      boton = 10'h000;
      for (int k = 1; k <= int'(TA + TC); k++) step();
      estado = 4'b1000;
      step();
   endtask

   task automatic test_reset_mid_open();
      estado = 4'b0000;
      step();
      n_checks++; if (s !== 10'h020) begin n_fail++; $display("FAIL f1_second_clear: got %h want 020", s); end
      step();
      n_checks++; if (puerta_abierta !== 1'b1) begin n_fail++; $display("FAIL pre_reset_puerta: got %b want 1", puerta_abierta); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (s !== 10'h000) begin n_fail++; $display("FAIL async_s: got %h want 000", s); end
      n_checks++; if (dut.state_q !== CERRADA) begin n_fail++; $display("FAIL async_state: got %0d want %0d", dut.state_q, CERRADA); end
      n_checks++; if (esperar !== 1'b0) begin n_fail++; $display("FAIL async_esperar: got %b want 0", esperar); end
      n_checks++; if (puerta_abierta !== 1'b0) begin n_fail++; $display("FAIL async_puerta: got %b want 0", puerta_abierta); end
      step();
      rst_n = 1'b1;
      step();
      n_checks++; if (s !== 10'h000) begin n_fail++; $display("FAIL post_reset_s: got %h want 000", s); end
      n_checks++; if (esperar !== 1'b0) begin n_fail++; $display("FAIL post_reset_esperar: got %b want 0", esperar); end
   endtask

   initial begin
      test_reset();
      test_edge_detect();
      test_stop_f1();
      test_stop_f3();
      test_reopen_cerrando();
      test_moving_latch();
      test_reset_mid_open();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
